vfo_dco: RTL and testbench

//  Synthesizable digitally controlled oscillator for the 1x PLL. Downstream consumer of the

---
 rtl/vfo_dco.sv | 134 +++++++++++++
 tb/tb_vfo_dco.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/vfo_dco.sv
// Digitally controlled oscillator for the 1x PLL: half-period counter with stepped adjustment,
// settle interval and lock detection. Define VFO_DITHER_EN for half-cycle frequency resolution.
module vfo_dco #(
  parameter int CNT_W     = 8,
  parameter int INIT_HALF = 16,
  parameter int MIN_HALF  = 2,
  parameter int MAX_HALF  = 255,
  parameter int STEP      = 1,
  parameter int SETTLE    = 4,
  parameter int LOCK_N    = 8
) (
  input  logic             FastClk,
  input  logic             Reset,
  input  logic [1:0]       AdjustFreq,
  output logic             PLLClock,
  output logic [CNT_W-1:0] HalfPeriod,
  output logic             Locked,
  output logic             AtLimit
);

`ifdef VFO_DITHER_EN
  localparam int FB = 1;
`else
  localparam int FB = 0;
`endif
  // hpFix holds the half-period in fixed point with FB fractional bits; AW adds headroom.
  localparam int HW = CNT_W + FB;
  localparam int AW = HW + 1;
  localparam int SW = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;
  localparam int LW = $clog2(LOCK_N + 1);

  localparam logic [AW-1:0] INIT_FIX = AW'(INIT_HALF << FB);
  localparam logic [AW-1:0] MIN_FIX  = AW'(MIN_HALF << FB);
  localparam logic [AW-1:0] MAX_FIX  = AW'(MAX_HALF << FB);
  localparam logic [AW-1:0] STEP_FIX = AW'(STEP);
  localparam logic [SW-1:0] SETTLE_V = SW'(SETTLE);
  localparam logic [LW-1:0] LOCK_MAX = LW'(LOCK_N);
  localparam logic [CNT_W:0] ONE_W   = (CNT_W+1)'(1);
  localparam logic INIT_AT_LIMIT = (INIT_FIX == MIN_FIX) || (INIT_FIX == MAX_FIX);

`ifndef SYNTHESIS
  if (MIN_HALF < 2 || MAX_HALF >= (1 << CNT_W) ||
      INIT_HALF < MIN_HALF || INIT_HALF > MAX_HALF) begin : gBadParams
    $fatal(1, "%m: illegal vfo_dco parameters (MIN_HALF/MAX_HALF/INIT_HALF)");
  end
`endif

  typedef enum logic {ST_SAMPLE, ST_SETTLE} adjState_t;

  logic [1:0]       adjMeta, adjSync;
  logic [CNT_W-1:0] cnt;
  logic [HW-1:0]    hpFix;
  adjState_t        state;
  logic [SW-1:0]    settleCnt;
  logic [LW-1:0]    lockCnt;

  logic [AW-1:0]    hpWide, hpUp, hpDown, hpNext;
  logic [CNT_W:0]   phaseLen;
  logic [LW-1:0]    lockNext;
  logic             phaseEnd, riseEvent, holdSample, speedUp, accept, atLimitNext;

  assign HalfPeriod = hpFix[HW-1:FB];

  always_comb begin
    hpWide = {1'b0, hpFix};
`ifdef VFO_DITHER_EN
    // Fractional half: the high phase gets the extra cycle, the low phase does not.
    phaseLen = {1'b0, hpFix[HW-1:1]} + {{CNT_W{1'b0}}, hpFix[0] & PLLClock};
`else
    phaseLen = {1'b0, hpFix};
`endif
    phaseEnd   = ({1'b0, cnt} == (phaseLen - ONE_W));
    riseEvent  = phaseEnd && !PLLClock;
    holdSample = adjSync[1] ^ adjSync[0];
    speedUp    = (adjSync == 2'b11);

    hpDown = (hpWide >= MIN_FIX + STEP_FIX) ? (hpWide - STEP_FIX) : MIN_FIX;
    if (hpDown < MIN_FIX) hpDown = MIN_FIX;
    hpUp = hpWide + STEP_FIX;
    if (hpUp > MAX_FIX) hpUp = MAX_FIX;

    accept = riseEvent && (state == ST_SAMPLE) && !holdSample;
    hpNext = hpWide;
    if (accept) hpNext = speedUp ? hpDown : hpUp;
    atLimitNext = (hpNext == MIN_FIX) || (hpNext == MAX_FIX);

    lockNext = lockCnt;
    if (riseEvent) begin
      if (!holdSample)             lockNext = '0;
      else if (lockCnt != LOCK_MAX) lockNext = lockCnt + LW'(1);
    end
  end

  always_ff @(posedge FastClk) begin
    if (Reset) begin
      adjMeta   <= 2'b01;
      adjSync   <= 2'b01;
      cnt       <= '0;
      PLLClock  <= 1'b0;
      hpFix     <= INIT_FIX[HW-1:0];
      state     <= ST_SAMPLE;
      settleCnt <= '0;
      lockCnt   <= '0;
      Locked    <= 1'b0;
      AtLimit   <= INIT_AT_LIMIT;
    end else begin
      adjMeta <= AdjustFreq;
      adjSync <= adjMeta;
      if (phaseEnd) begin
        cnt      <= '0;
        PLLClock <= ~PLLClock;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
      hpFix   <= hpNext[HW-1:0];
      AtLimit <= atLimitNext;
      lockCnt <= lockNext;
      Locked  <= (lockNext == LOCK_MAX);
      if (riseEvent) begin
        case (state)
          ST_SAMPLE: if (accept && SETTLE > 0) begin
            state     <= ST_SETTLE;
            settleCnt <= SETTLE_V;
          end
          ST_SETTLE: begin
            settleCnt <= settleCnt - SW'(1);
            if (settleCnt == SW'(1)) state <= ST_SAMPLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_vfo_dco.sv
// Directed bench for vfo_dco: default instance for start-up, lock, speed-up and reset,
// plus an instance started near the top clamp to exercise saturation at MAX_HALF.
module tb_vfo_dco;
  localparam int RISE_LIMIT = 1200;

  logic       FastClk = 1'b0;
  logic       Reset, Reset2;
  logic [1:0] AdjustFreq, AdjustFreq2;
  logic       pll1, locked1, atLimit1, pll2, locked2, atLimit2;
  logic [7:0] hp1, hp2;

  int checks = 0;
  int failures = 0;

  always #5 FastClk = ~FastClk;

  vfo_dco dut (
    .FastClk(FastClk), .Reset(Reset), .AdjustFreq(AdjustFreq),
    .PLLClock(pll1), .HalfPeriod(hp1), .Locked(locked1), .AtLimit(atLimit1)
  );

  vfo_dco #(.INIT_HALF(253)) dutHigh (
    .FastClk(FastClk), .Reset(Reset2), .AdjustFreq(AdjustFreq2),
    .PLLClock(pll2), .HalfPeriod(hp2), .Locked(locked2), .AtLimit(atLimit2)
  );

  task automatic checkEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end else begin
      $display("ok   %s: %0d", tag, obs);
    end
  endtask

  // Called just after a negedge; returns the number of negedges until PLLClock is seen rising.
  task automatic waitRise(input int sel, output int cycles);
    logic prev, cur;
    int riseSeen;
    riseSeen = 0;
    cycles = 0;
    prev = sel ? pll2 : pll1;
    for (int n = 1; n <= RISE_LIMIT; n++) begin
      @(negedge FastClk);
      cur = sel ? pll2 : pll1;
      if (!prev && cur) begin
        cycles = n;
        riseSeen = 1;
        break;
      end
      prev = cur;
    end
    if (riseSeen == 0) checkEq("rise_timeout", riseSeen, 1);
  endtask

  task automatic skipRises(input int sel, input int count);
    int c;
    for (int i = 0; i < count; i++) waitRise(sel, c);
  endtask

  initial begin
    int cyc;
    int n;
    Reset = 1'b1;
    Reset2 = 1'b1;
    AdjustFreq = 2'b01;
    AdjustFreq2 = 2'b00;

    // Start-up, period and lock
    repeat (3) @(negedge FastClk);
    checkEq("reset_pll", pll1, 0);
    checkEq("reset_hp", hp1, 16);
    checkEq("reset_locked", locked1, 0);
    checkEq("reset_atlimit", atLimit1, 0);
    Reset = 1'b0;
    waitRise(0, cyc);
    checkEq("first_rise_cycles", cyc, 16);
    waitRise(0, cyc);
    checkEq("period_hp16", cyc, 32);
    skipRises(0, 5);
    checkEq("locked_rise7", locked1, 0);
    skipRises(0, 1);
    checkEq("locked_rise8", locked1, 1);

    // Single speed-up sample breaks lock and steps once
    AdjustFreq = 2'b11;
    skipRises(0, 1);
    checkEq("single11_hp", hp1, 15);
    checkEq("single11_locked", locked1, 0);
    AdjustFreq = 2'b01;
    waitRise(0, cyc);
    checkEq("period_hp15", cyc, 30);
    skipRises(0, 6);
    checkEq("relock_rise16_locked", locked1, 0);
    checkEq("relock_rise16_hp", hp1, 15);
    skipRises(0, 1);
    checkEq("relock_rise17_locked", locked1, 1);

    // Held speed-up: one step per 5 rises down to the MIN clamp
    AdjustFreq = 2'b11;
    skipRises(0, 1);
    checkEq("speed_rise18_hp", hp1, 14);
    checkEq("speed_rise18_locked", locked1, 0);
    skipRises(0, 4);
    checkEq("settle_rise22_hp", hp1, 14);
    skipRises(0, 1);
    checkEq("speed_rise23_hp", hp1, 13);
    skipRises(0, 54);
    checkEq("speed_rise77_hp", hp1, 3);
    checkEq("speed_rise77_atlimit", atLimit1, 0);
    skipRises(0, 1);
    checkEq("min_rise78_hp", hp1, 2);
    checkEq("min_rise78_atlimit", atLimit1, 1);
    skipRises(0, 5);
    waitRise(0, cyc);
    checkEq("min_hold_hp", hp1, 2);
    checkEq("min_hold_atlimit", atLimit1, 1);
    checkEq("period_hp2", cyc, 4);

    // Climb back to 10, then reset in the middle of a high phase
    AdjustFreq = 2'b00;
    n = 0;
    for (int i = 1; i <= 60; i++) begin
      skipRises(0, 1);
      if (hp1 == 8'd10) begin
        n = i;
        break;
      end
    end
    checkEq("climb_rises_to_10", n, 39);
    AdjustFreq = 2'b01;
    skipRises(0, 1);
    repeat (4) @(negedge FastClk);
    checkEq("mid_high_pll", pll1, 1);
    checkEq("mid_high_hp", hp1, 10);
    Reset = 1'b1;
    @(negedge FastClk);
    checkEq("midreset_pll", pll1, 0);
    checkEq("midreset_hp", hp1, 16);
    checkEq("midreset_locked", locked1, 0);
    checkEq("midreset_atlimit", atLimit1, 0);
    Reset = 1'b0;
    waitRise(0, cyc);
    checkEq("midreset_first_rise", cyc, 16);

    // Upper clamp: start at 253, hold slow-down
    Reset2 = 1'b0;
    waitRise(1, cyc);
    checkEq("high_first_rise", cyc, 253);
    checkEq("high_rise1_hp", hp2, 254);
    checkEq("high_rise1_atlimit", atLimit2, 0);
    skipRises(1, 4);
    checkEq("high_rise5_hp", hp2, 254);
    skipRises(1, 1);
    checkEq("high_rise6_hp", hp2, 255);
    checkEq("high_rise6_atlimit", atLimit2, 1);
    skipRises(1, 5);
    checkEq("high_rise11_hp", hp2, 255);
    checkEq("high_rise11_atlimit", atLimit2, 1);
    waitRise(1, cyc);
    checkEq("period_hp255", cyc, 510);
    checkEq("high_rise12_hp", hp2, 255);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
